reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file for the MIPS datapath, the successor to the single-write, dual-read `reg_file`. It supports configurable data width, depth, read-port count and write-port count, with optional write-to-read bypass and an optional hard-wired zero register. A per-register busy scoreboard lets the decode stage detect RAW hazards against in-flight producers. It sits between decode (read and reserve) and writeback (write and release).

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth `NREGS = 2**ADDR_W`.
- `NUM_RD`, 2: read ports, range 1..4.
- `NUM_WR`, 1: write ports, range 1..2.
- `BYPASS`, 1: 1 = a same-cycle write is forwarded to matching reads.
- `ZERO_REG`, 1: 1 = register 0 always reads 0 and is never written or reserved.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `readReg`, input, `NUM_RD*ADDR_W`: read addresses. Port *i* is slice *i*.
- `readData`, output, `NUM_RD*DATA_W`: read data, combinational.
- `readBusy`, output, `NUM_RD`: busy bit of the addressed register, combinational.
- `writeReg`, input, `NUM_WR*ADDR_W`: write addresses.
- `writeData`, input, `NUM_WR*DATA_W`: write data.
- `regWrite`, input, `NUM_WR`: write enables.
- `resvEn`, input, 1: reserve request from decode.
- `resvReg`, input, `ADDR_W`: register to mark busy.
- `busyVec`, output, `NREGS`: full scoreboard, registered.

## Operation
- **Storage:** `NREGS` × `DATA_W` flops, plus `NREGS` busy flops.
- **Reset:** on a rising edge with `reset`=1, all registers clear to 0 and all busy bits clear to 0. `reset` overrides writes and reserves in that cycle.
- **Write:** on a rising edge with `regWrite[j]`=1, `writeData[j]` is stored to `writeReg[j]`.
  - If both ports target the same register in one cycle, port 1 wins.
  - Writes to register 0 are dropped when `ZERO_REG`=1.
- **Read:**
  - `readData[i]` = the stored value of `readReg[i]`.
  - If `BYPASS`=1, `reset`=0, and some enabled write port targets `readReg[i]`, the read returns that port's `writeData` instead. The same port-1 priority applies.
  - If `ZERO_REG`=1 and `readReg[i]`=0, the read returns 0 regardless of bypass.
- **Scoreboard:**
  - `resvEn` sets `busy[resvReg]` at the edge.
  - An enabled write clears `busy[writeReg[j]]`.
  - Reserve and write to the same register in the same cycle: reserve wins, so the bit stays 1 (a newer producer has been issued).
  - Reserving register 0 with `ZERO_REG`=1 is ignored.
- **Busy read:** `readBusy[i]` = `busy[readReg[i]]`, forced to 0 for register 0 when `ZERO_REG`=1.
  - When `BYPASS`=1, a same-cycle write to that register (with no same-cycle reserve) forces `readBusy[i]` to 0.
- **Address range:** out-of-range addresses cannot occur, since depth is exactly `2**ADDR_W`.

## Timing
- Write latency without bypass: visible on `readData` in the cycle after the edge.
- Write latency with bypass: visible in the same cycle, before the edge.
- Reserve latency: `busyVec` and `readBusy` go high in the cycle after the `resvEn` edge.
- Reads have no enable and no latency; they are purely combinational from `readReg` and state.
- Reset values:
  - `busyVec` = 0.
  - `readData` = 0 and `readBusy` = 0 for every address, from the first cycle after reset.
- Reset asserted mid-operation: pending writes and reserves in that cycle are discarded. Bypass is suppressed while `reset`=1, so reads return the pre-reset array contents until the edge.

## Structure
- Shared package `reg_file_pkg`:
  - Default widths (`DATA_W_DEF`=32, `ADDR_W_DEF`=5).
  - The MIPS register-index constant `REG_ZERO`=0.
- One sub-module, `reg_file_scoreboard`:
  - Holds the busy flops, reserve/release priority and `busyVec`.
  - Takes `clk`, `reset`, reserve inputs and the write enable/address buses.
- The data array, write-priority merge and per-port read/bypass muxes stay in the top module, generated over `NUM_RD`/`NUM_WR`.

## Test plan
- **Fill and read:** Defaults (`NUM_RD`=2, `NUM_WR`=1). Write `10+r` to each `r` in 0..31, then read (0,2) and (31,17). Required: (0,12) and (41,27), since register 0 stays 0.
- **Bypass on/off:** Write `0xDEAD_BEEF` to r5 while reading r5 in the same cycle. Required with `BYPASS`=1: `0xDEADBEEF` immediately. Required with `BYPASS`=0: the old value, then `0xDEADBEEF` the next cycle.
- **Dual-write conflict:** `NUM_WR`=2, both ports write r7 (port 0 = 1, port 1 = 2). Required: r7 reads 2 afterwards, and the bypass read in the same cycle is also 2.
- **Scoreboard:**
  - Reserve r9. Required next cycle: `readBusy`=1, `busyVec[9]`=1.
  - Write r9. Required: busy clears the cycle after.
  - Reserve and write r9 in the same cycle. Required: busy stays 1.
  - Reserve r0. Required: `busyVec`=0.
- **Reset mid-operation:** Registers hold non-zero values and r3 is busy. Assert `reset` for one cycle together with a write to r4 and a reserve of r6. Required afterwards: all reads 0, `busyVec`=0, r4=0.
- **`NUM_RD`=4:** Read r1..r4 concurrently after writing distinct values. Required: every port returns its own value, with no cross-port aliasing.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_mp shared constants
// default widths and MIPS register indices
package reg_file_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_mp bus: read, write and
// reserve ports between decode/writeback
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [NUM_RD*ADDR_W-1:0] readReg;
  logic [NUM_RD*DATA_W-1:0] readData;
  logic [NUM_RD-1:0]        readBusy;
  logic [NUM_WR*ADDR_W-1:0] writeReg;
  logic [NUM_WR*DATA_W-1:0] writeData;
  logic [NUM_WR-1:0]        regWrite;
  logic                     resvEn;
  logic [ADDR_W-1:0]        resvReg;
  logic [NREGS-1:0]         busyVec;

  modport master (
    output readReg, writeReg, writeData,
    output regWrite, resvEn, resvReg,
    input  readData, readBusy, busyVec
  );

  modport slave (
    input  readReg, writeReg, writeData,
    input  regWrite, resvEn, resvReg,
    output readData, readBusy, busyVec
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Busy scoreboard: decode reserves,
// writeback releases, reserve wins ties
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_resv_en,
  input  logic [ADDR_W-1:0]        i_resv_reg,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_reg,
  input  logic [NUM_WR-1:0]        i_wr_en,
  output logic [2**ADDR_W-1:0]     o_busy
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] R0 =
    ADDR_W'(REG_ZERO);

  logic [NREGS-1:0] r_busy;
  logic             w_resv_ok;

  assign w_resv_ok = i_resv_en &&
    !((ZERO_REG != 0) && (i_resv_reg == R0));

  // release on write, then reserve overrides
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (i_wr_en[j])
          r_busy[i_wr_reg[j*ADDR_W +: ADDR_W]]
            <= 1'b0;
      end
      if (w_resv_ok)
        r_busy[i_resv_reg] <= 1'b1;
    end
  end

  assign o_busy = r_busy;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with optional
// write bypass, zero register and scoreboard
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic     clk,
  input  logic     reset,
  reg_file_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] R0 =
    ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [ADDR_W-1:0] w_wa  [NUM_WR];
  logic [DATA_W-1:0] w_wd  [NUM_WR];
  logic [NUM_WR-1:0] w_we;
  logic [NREGS-1:0]  w_busy;

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign w_wa[j] =
      bus.writeReg[j*ADDR_W +: ADDR_W];
    assign w_wd[j] =
      bus.writeData[j*DATA_W +: DATA_W];
  end
  assign w_we = bus.regWrite;

  // array write; later port overrides earlier
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++)
        r_mem[k] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (w_we[j] &&
            !((ZERO_REG != 0) && (w_wa[j] == R0)))
          r_mem[w_wa[j]] <= w_wd[j];
      end
    end
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_resv_en  (bus.resvEn),
    .i_resv_reg (bus.resvReg),
    .i_wr_reg   (bus.writeReg),
    .i_wr_en    (bus.regWrite),
    .o_busy     (w_busy)
  );

  assign bus.busyVec = w_busy;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [DATA_W-1:0] w_rd;
    logic              w_rb;
    logic              w_rsv;

    assign w_ra =
      bus.readReg[i*ADDR_W +: ADDR_W];
    assign w_rsv =
      bus.resvEn && (bus.resvReg == w_ra);

    // stored value, bypass, then zero register
    always_comb begin
      w_rd = r_mem[w_ra];
      w_rb = w_busy[w_ra];
      if ((BYPASS != 0) && !reset) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (w_we[j] && (w_wa[j] == w_ra)) begin
            w_rd = w_wd[j];
            if (!w_rsv)
              w_rb = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (w_ra == R0)) begin
        w_rd = '0;
        w_rb = 1'b0;
      end
    end

    assign bus.readData[i*DATA_W +: DATA_W] = w_rd;
    assign bus.readBusy[i] = w_rb;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: bypass 4R/2W and
// plain 2R/1W instances vs a reference model
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(32), .ADDR_W(5),
    .NUM_RD(4), .NUM_WR(2)) bus_a ();
  reg_file_if #(.DATA_W(32), .ADDR_W(5),
    .NUM_RD(2), .NUM_WR(1)) bus_b ();

  reg_file_mp #(.DATA_W(32), .ADDR_W(5),
    .NUM_RD(4), .NUM_WR(2), .BYPASS(1),
    .ZERO_REG(1)) u_a (
    .clk(clk), .reset(rst), .bus(bus_a));

  reg_file_mp #(.DATA_W(32), .ADDR_W(5),
    .NUM_RD(2), .NUM_WR(1), .BYPASS(0),
    .ZERO_REG(1)) u_b (
    .clk(clk), .reset(rst), .bus(bus_b));

  int checks = 0;
  int fails  = 0;

  logic [4:0]  ra [4];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic        we [2];
  logic        resv;
  logic [4:0]  rr;

  logic [31:0] ma [32];
  logic        ba [32];
  logic [31:0] mb [32];
  logic        bb [32];

  task automatic chk(string tag,
      logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h",
        tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    resv = 1'b0;
    rr = '0;
    for (int j = 0; j < 2; j++) begin
      we[j] = 1'b0; wa[j] = '0; wd[j] = '0;
    end
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++)
      bus_a.readReg[i*5 +: 5] = ra[i];
    for (int i = 0; i < 2; i++)
      bus_b.readReg[i*5 +: 5] = ra[i];
    for (int j = 0; j < 2; j++) begin
      bus_a.writeReg[j*5 +: 5] = wa[j];
      bus_a.writeData[j*32 +: 32] = wd[j];
      bus_a.regWrite[j] = we[j];
    end
    bus_b.writeReg = wa[0];
    bus_b.writeData = wd[0];
    bus_b.regWrite[0] = we[0];
    bus_a.resvEn = resv;
    bus_a.resvReg = rr;
    bus_b.resvEn = resv;
    bus_b.resvReg = rr;
  endtask

  // value a reader sees this cycle
  function automatic logic [31:0] exp_da(
      logic [4:0] a);
    logic [31:0] d;
    if (a == 0) return 0;
    d = ma[a];
    if (!rst) begin
      if (we[0] && wa[0] == a) d = wd[0];
      if (we[1] && wa[1] == a) d = wd[1];
    end
    return d;
  endfunction

  function automatic logic exp_ba(
      logic [4:0] a);
    logic hit;
    if (a == 0) return 1'b0;
    hit = (we[0] && wa[0] == a) ||
          (we[1] && wa[1] == a);
    if (!rst && hit && !(resv && rr == a))
      return 1'b0;
    return ba[a];
  endfunction

  function automatic logic [31:0] exp_db(
      logic [4:0] a);
    return (a == 0) ? 32'd0 : mb[a];
  endfunction

  function automatic logic exp_bb(
      logic [4:0] a);
    return (a == 0) ? 1'b0 : bb[a];
  endfunction

  task automatic check_all();
    logic [31:0] va, vb;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("a_rd%0d", i),
        bus_a.readData[i*32 +: 32],
        exp_da(ra[i]));
      chk($sformatf("a_busy%0d", i),
        32'(bus_a.readBusy[i]),
        32'(exp_ba(ra[i])));
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("b_rd%0d", i),
        bus_b.readData[i*32 +: 32],
        exp_db(ra[i]));
      chk($sformatf("b_busy%0d", i),
        32'(bus_b.readBusy[i]),
        32'(exp_bb(ra[i])));
    end
    for (int k = 0; k < 32; k++) begin
      va[k] = ba[k];
      vb[k] = bb[k];
    end
    chk("a_busyvec", bus_a.busyVec, va);
    chk("b_busyvec", bus_b.busyVec, vb);
  endtask

  task automatic drive(bit do_chk = 1'b1);
    apply();
    #1;
    if (do_chk) check_all();
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) begin
        ma[k] = 0; ba[k] = 0;
        mb[k] = 0; bb[k] = 0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (we[j]) begin
          if (wa[j] != 0) ma[wa[j]] = wd[j];
          ba[wa[j]] = 1'b0;
        end
      end
      if (we[0]) begin
        if (wa[0] != 0) mb[wa[0]] = wd[0];
        bb[wa[0]] = 1'b0;
      end
      if (resv && rr != 0) begin
        ba[rr] = 1'b1;
        bb[rr] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      ma[k] = 0; ba[k] = 0;
      mb[k] = 0; bb[k] = 0;
    end
    for (int i = 0; i < 4; i++) ra[i] = 5'(i);
    idle();
    rst = 1'b1;
    apply();
    @(negedge clk);
    drive(1'b0);
    edge_step();

    // reset state
    idle();
    for (int i = 0; i < 4; i++)
      ra[i] = 5'($urandom);
    drive();
    edge_step();

    // fill
    for (int r = 0; r < 32; r++) begin
      idle();
      we[0] = 1'b1; wa[0] = 5'(r);
      wd[0] = 32'(10 + r);
      for (int i = 0; i < 4; i++)
        ra[i] = 5'($urandom);
      drive();
      edge_step();
    end
    idle();
    ra[0] = 5'd0; ra[1] = 5'd2;
    ra[2] = 5'd31; ra[3] = 5'd17;
    drive();
    chk("fill_r0", bus_a.readData[31:0], 0);
    chk("fill_r2", bus_a.readData[63:32], 12);
    chk("fill_r31", bus_a.readData[95:64], 41);
    chk("fill_r17", bus_a.readData[127:96], 27);
    chk("fill_b_r2", bus_b.readData[63:32], 12);
    edge_step();

    // bypass on/off
    idle();
    ra[0] = 5'd5;
    we[0] = 1'b1; wa[0] = 5'd5;
    wd[0] = 32'hDEAD_BEEF;
    drive();
    chk("byp_a", bus_a.readData[31:0],
      32'hDEAD_BEEF);
    chk("byp_b_old", bus_b.readData[31:0], 15);
    edge_step();
    idle();
    drive();
    chk("byp_b_new", bus_b.readData[31:0],
      32'hDEAD_BEEF);
    edge_step();

    // dual-write conflict
    idle();
    ra[0] = 5'd7;
    we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 1;
    we[1] = 1'b1; wa[1] = 5'd7; wd[1] = 2;
    drive();
    chk("dual_byp", bus_a.readData[31:0], 2);
    edge_step();
    idle();
    drive();
    chk("dual_r7", bus_a.readData[31:0], 2);
    edge_step();

    // scoreboard
    idle();
    ra[0] = 5'd9;
    resv = 1'b1; rr = 5'd9;
    drive();
    edge_step();
    idle();
    drive();
    chk("sb_rb9", 32'(bus_a.readBusy[0]), 1);
    chk("sb_bv9", 32'(bus_a.busyVec[9]), 1);
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 99;
    drive();
    edge_step();
    idle();
    drive();
    chk("sb_clr9", 32'(bus_a.busyVec[9]), 0);
    resv = 1'b1; rr = 5'd9;
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 98;
    drive();
    edge_step();
    idle();
    drive();
    chk("sb_tie9", 32'(bus_a.busyVec[9]), 1);
    chk("sb_tie9b", 32'(bus_b.busyVec[9]), 1);
    we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 97;
    drive();
    edge_step();
    idle();
    resv = 1'b1; rr = 5'd0;
    drive();
    edge_step();
    idle();
    drive();
    chk("sb_r0", bus_a.busyVec, 0);
    edge_step();

    // reset mid-operation
    idle();
    resv = 1'b1; rr = 5'd3;
    drive();
    edge_step();
    idle();
    rst = 1'b1;
    we[0] = 1'b1; wa[0] = 5'd4; wd[0] = 55;
    resv = 1'b1; rr = 5'd6;
    ra[0] = 5'd4; ra[1] = 5'd2;
    drive();
    chk("rst_nobyp", bus_a.readData[31:0], 14);
    edge_step();
    idle();
    ra[0] = 5'd4; ra[1] = 5'd3;
    ra[2] = 5'd6; ra[3] = 5'd31;
    drive();
    chk("rst_r4", bus_a.readData[31:0], 0);
    chk("rst_r31", bus_a.readData[127:96], 0);
    chk("rst_bv", bus_a.busyVec, 0);
    edge_step();

    // four concurrent reads
    idle();
    we[0] = 1'b1; wa[0] = 5'd1; wd[0] = 101;
    we[1] = 1'b1; wa[1] = 5'd2; wd[1] = 102;
    drive();
    edge_step();
    idle();
    we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 103;
    we[1] = 1'b1; wa[1] = 5'd4; wd[1] = 104;
    drive();
    edge_step();
    idle();
    for (int i = 0; i < 4; i++) ra[i] = 5'(i + 1);
    drive();
    for (int i = 0; i < 4; i++)
      chk($sformatf("rd4_p%0d", i),
        bus_a.readData[i*32 +: 32],
        32'(101 + i));
    edge_step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 4; i++)
        ra[i] = 5'($urandom_range(0, 11));
      for (int j = 0; j < 2; j++) begin
        we[j] = ($urandom_range(0, 2) != 0);
        wa[j] = 5'($urandom_range(0, 11));
        wd[j] = $urandom;
      end
      resv = ($urandom_range(0, 1) != 0);
      rr = 5'($urandom_range(0, 11));
      drive();
      edge_step();
    end
    idle();
    drive();

    $display("%0d/%0d checks passed",
      checks - fails, checks);
    $finish;
  end
endmodule
